// File: rtl/ota_cal_seq.sv
// ----------------------------------------------------------------------------
// ota_cal_seq
//
// Sequencer for the digital OTA/comparator cell. With the OTA inputs shorted
// it runs a successive-approximation offset-trim search, then releases the
// short, enables the OTA output driver and samples the comparator once every
// RUN_PERIOD cycles.
//
// Parameters
//   TRIM_W      width of the offset-trim code (SAR bits), >= 2
//   SETTLE      cycles spent on each SAR bit, including the 2-cycle
//               comparator synchroniser, >= 3
//   RUN_PERIOD  cycles between comparator samples in RUN, >= 2
//
// Ports
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   ena           in   block enable; low forces IDLE (priority over cal_start)
//   cal_start     in   level; starts calibration from IDLE or RUN
//   cmp_in        in   raw comparator output, asynchronous to clk
//   trim_code     out  offset-trim code to the OTA
//   short_en      out  1 = short Vip/Vin together during calibration
//   ota_en        out  1 = enable the OTA output tristate driver
//   cal_busy      out  1 while in CAL_INIT / CAL_BIT
//   cal_done      out  sticky 1 after a completed calibration
//   sample_valid  out  1-cycle pulse, sample_bit valid
//   sample_bit    out  synchronised comparator value captured with the pulse
// ----------------------------------------------------------------------------
module ota_cal_seq #(
    parameter int TRIM_W     = 4,
    parameter int SETTLE     = 8,
    parameter int RUN_PERIOD = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              cal_start,
    input  logic              cmp_in,
    output logic [TRIM_W-1:0] trim_code,
    output logic              short_en,
    output logic              ota_en,
    output logic              cal_busy,
    output logic              cal_done,
    output logic              sample_valid,
    output logic              sample_bit
);

    localparam int IDX_W = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;
    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int PER_W = (RUN_PERIOD > 1) ? $clog2(RUN_PERIOD) : 1;

    localparam logic [IDX_W-1:0]  IDX_TOP  = IDX_W'(TRIM_W - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
    localparam logic [SET_W-1:0]  SET_LAST = SET_W'(SETTLE - 1);
    localparam logic [SET_W-1:0]  SET_ONE  = SET_W'(1);
    localparam logic [PER_W-1:0]  PER_LAST = PER_W'(RUN_PERIOD - 1);
    localparam logic [PER_W-1:0]  PER_ONE  = PER_W'(1);
    localparam logic [TRIM_W-1:0] TRIM_ONE = TRIM_W'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CAL_INIT = 2'd1,
        CAL_BIT  = 2'd2,
        RUN      = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               cmp_s1_q;
    logic               cmp_s_q;
    logic [TRIM_W-1:0]  trim_q, trim_d;
    logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
    logic [SET_W-1:0]   set_cnt_q, set_cnt_d;
    logic [PER_W-1:0]   per_cnt_q, per_cnt_d;
    logic               short_q, short_d;
    logic               ota_q, ota_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               sv_q, sv_d;
    logic               sb_q, sb_d;

    // Helper terms for the SAR step
    logic [TRIM_W-1:0]  cur_mask;
    logic [TRIM_W-1:0]  nxt_mask;
    logic [IDX_W-1:0]   nxt_idx;
    logic [TRIM_W-1:0]  resolved;

    // ------------------------------------------------------------------
    // Comparator synchroniser; only cmp_s_q is used by the sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_s1_q <= 1'b0;
            cmp_s_q  <= 1'b0;
        end else begin
            cmp_s1_q <= cmp_in;
            cmp_s_q  <= cmp_s1_q;
        end
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            trim_q    <= '0;
            bit_idx_q <= '0;
            set_cnt_q <= '0;
            per_cnt_q <= '0;
            short_q   <= 1'b0;
            ota_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sv_q      <= 1'b0;
            sb_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            trim_q    <= trim_d;
            bit_idx_q <= bit_idx_d;
            set_cnt_q <= set_cnt_d;
            per_cnt_q <= per_cnt_d;
            short_q   <= short_d;
            ota_q     <= ota_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            sv_q      <= sv_d;
            sb_q      <= sb_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Outputs are registered, so every output change is
    // scheduled on the transition into the state that owns it.
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        trim_d    = trim_q;
        bit_idx_d = bit_idx_q;
        set_cnt_d = set_cnt_q;
        per_cnt_d = per_cnt_q;
        short_d   = short_q;
        ota_d     = ota_q;
        busy_d    = busy_q;
        done_d    = done_q;
        sv_d      = 1'b0;
        sb_d      = sb_q;

        cur_mask = TRIM_ONE << bit_idx_q;
        nxt_idx  = bit_idx_q - IDX_ONE;
        nxt_mask = TRIM_ONE << nxt_idx;
        // A high comparator means the trial code overshot: drop the trial bit
        resolved = cmp_s_q ? (trim_q & ~cur_mask) : trim_q;

        if (!ena) begin
            state_d = IDLE;
            short_d = 1'b0;
            ota_d   = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            // An aborted search keeps only the bits already decided; the
            // pending trial bit is unresolved and is withdrawn.
            if (state_q == CAL_BIT) begin
                trim_d = trim_q & ~cur_mask;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cal_start) begin
                        state_d   = CAL_INIT;
                        trim_d    = '0;
                        bit_idx_d = IDX_TOP;
                        short_d   = 1'b1;
                        busy_d    = 1'b1;
                        done_d    = 1'b0;
                        ota_d     = 1'b0;
                    end
                end

                CAL_INIT: begin
                    // First trial: MSB set
                    state_d   = CAL_BIT;
                    trim_d    = trim_q | cur_mask;
                    set_cnt_d = '0;
                end

                CAL_BIT: begin
                    if (set_cnt_q == SET_LAST) begin
                        if (bit_idx_q == '0) begin
                            state_d   = RUN;
                            trim_d    = resolved;
                            short_d   = 1'b0;
                            busy_d    = 1'b0;
                            done_d    = 1'b1;
                            ota_d     = 1'b1;
                            per_cnt_d = '0;
                        end else begin
                            // Decide this bit and launch the next trial together
                            trim_d    = resolved | nxt_mask;
                            bit_idx_d = nxt_idx;
                            set_cnt_d = '0;
                        end
                    end else begin
                        set_cnt_d = set_cnt_q + SET_ONE;
                    end
                end

                RUN: begin
                    if (cal_start) begin
                        state_d   = CAL_INIT;
                        trim_d    = '0;
                        bit_idx_d = IDX_TOP;
                        short_d   = 1'b1;
                        busy_d    = 1'b1;
                        done_d    = 1'b0;
                        ota_d     = 1'b0;
                    end else if (per_cnt_q == PER_LAST) begin
                        per_cnt_d = '0;
                        sv_d      = 1'b1;
                        sb_d      = cmp_s_q;
                    end else begin
                        per_cnt_d = per_cnt_q + PER_ONE;
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign trim_code    = trim_q;
    assign short_en     = short_q;
    assign ota_en       = ota_q;
    assign cal_busy     = busy_q;
    assign cal_done     = done_q;
    assign sample_valid = sv_q;
    assign sample_bit   = sb_q;

endmodule

// File: tb/tb_ota_cal_seq.sv
// ----------------------------------------------------------------------------
// tb_ota_cal_seq
//
// Self-checking bench for ota_cal_seq (TRIM_W=4, SETTLE=4, RUN_PERIOD=16).
// The comparator is either modelled as cmp_in = (trim_code >= thr) or driven
// directly by the bench. Expected trims come from a table and from a
// brute-force "largest code whose comparator reads 0" search; expected trial
// sequences come from a plain successive-approximation loop.
// ----------------------------------------------------------------------------
module tb_ota_cal_seq;

    localparam int TRIM_W     = 4;
    localparam int SETTLE     = 4;
    localparam int RUN_PERIOD = 16;
    localparam int CAL_LEN    = 1 + TRIM_W * SETTLE;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ena;
    logic              cal_start;
    logic              cmp_in;
    logic [TRIM_W-1:0] trim_code;
    logic              short_en;
    logic              ota_en;
    logic              cal_busy;
    logic              cal_done;
    logic              sample_valid;
    logic              sample_bit;

    logic model_on;
    logic cmp_man;
    int   thr;

    assign cmp_in = model_on ? (int'(trim_code) >= thr) : cmp_man;

    ota_cal_seq #(
        .TRIM_W    (TRIM_W),
        .SETTLE    (SETTLE),
        .RUN_PERIOD(RUN_PERIOD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .cal_start   (cal_start),
        .cmp_in      (cmp_in),
        .trim_code   (trim_code),
        .short_en    (short_en),
        .ota_en      (ota_en),
        .cal_busy    (cal_busy),
        .cal_done    (cal_done),
        .sample_valid(sample_valid),
        .sample_bit  (sample_bit)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    int seen[$];
    int ref_trials[$];

    typedef struct {
        string name;
        int    thr;
        int    exp_trim;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Largest code whose comparator output is 0 (0 if none)
    function automatic int best_code(input int t);
        int best = 0;
        for (int c = 0; c < (1 << TRIM_W); c++)
            if (!(c >= t)) best = c;
        return best;
    endfunction

    // Trial codes a binary search presents, MSB first
    function automatic void sar_trials(input int t);
        int code = 0;
        ref_trials.delete();
        for (int b = TRIM_W - 1; b >= 0; b--) begin
            int trial = code + (1 << b);
            ref_trials.push_back(trial);
            if (!(trial >= t)) code = trial;
        end
    endfunction

    task automatic cmp_trials(input string tag);
        check({tag, " n_trials"}, seen.size(), ref_trials.size());
        for (int i = 0; i < ref_trials.size() && i < seen.size(); i++)
            check($sformatf("%s trial%0d", tag, i), seen[i], ref_trials[i]);
    endtask

    // Starts a calibration at a negedge and follows it until cal_busy falls.
    // poke re-asserts cal_start mid-calibration, which must have no effect.
    task automatic run_cal(input string tag, input int t, input int exp_trim, input bit poke);
        int cyc;
        int last;
        bit short_ok;
        model_on = 1'b1;
        thr      = t;
        seen.delete();
        cal_start = 1'b1;
        @(negedge clk);
        cal_start = 1'b0;
        check({tag, " busy_start"}, cal_busy, 1);
        check({tag, " done_clr"}, cal_done, 0);
        check({tag, " ota_off"}, ota_en, 0);
        cyc = 0;
        last = 0;
        short_ok = 1'b1;
        while (cal_busy && cyc < 200) begin
            cyc++;
            if (!short_en) short_ok = 1'b0;
            if (int'(trim_code) != last) begin
                seen.push_back(int'(trim_code));
                last = int'(trim_code);
            end
            if (poke && cyc == 5) cal_start = 1'b1;
            if (poke && cyc == 8) cal_start = 1'b0;
            @(negedge clk);
        end
        check({tag, " busy_len"}, cyc, CAL_LEN);
        check({tag, " short_during"}, short_ok, 1);
        check({tag, " trim"}, int'(trim_code), exp_trim);
        check({tag, " cal_done"}, cal_done, 1);
        check({tag, " ota_en"}, ota_en, 1);
        check({tag, " short_after"}, short_en, 0);
    endtask

    task automatic wait_pulse(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sample_valid && n < 100);
        if (!sample_valid) n = -1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " trim"}, int'(trim_code), 0);
        check({tag, " short_en"}, short_en, 0);
        check({tag, " ota_en"}, ota_en, 0);
        check({tag, " cal_busy"}, cal_busy, 0);
        check({tag, " cal_done"}, cal_done, 0);
        check({tag, " sample_valid"}, sample_valid, 0);
        check({tag, " sample_bit"}, sample_bit, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int t;
        int last_pulse;
        int pulses;
        int activity;
        int v;
        int hist[$];

        vecs[0] = '{"V_thr9",  9,  8};
        vecs[1] = '{"V_all1",  0,  0};
        vecs[2] = '{"V_all0",  16, 15};
        vecs[3] = '{"V_thr1",  1,  0};
        vecs[4] = '{"V_thr15", 15, 14};
        vecs[5] = '{"V_thr5",  5,  4};
        vecs[6] = '{"V_thr8",  8,  7};

        rst_n = 1'b0;
        ena = 1'b0;
        cal_start = 1'b0;
        cmp_man = 1'b0;
        model_on = 1'b0;
        thr = 0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        ena = 1'b1;
        @(negedge clk);

        // Basic calibration with the known trial sequence
        run_cal("T2", 9, 8, 1'b0);
        ref_trials = '{8, 12, 10, 9};
        cmp_trials("T2");

        // Table of comparator thresholds, each recalibrating from RUN
        for (int i = 0; i < 7; i++) begin
            run_cal(vecs[i].name, vecs[i].thr, vecs[i].exp_trim, 1'b0);
            sar_trials(vecs[i].thr);
            cmp_trials(vecs[i].name);
        end

        // Random thresholds against the reference search
        for (int i = 0; i < 5; i++) begin
            t = int'($urandom_range(16, 0));
            run_cal($sformatf("R%0d_thr%0d", i, t), t, best_code(t), 1'b0);
            sar_trials(t);
            cmp_trials($sformatf("R%0d", i));
        end

        // cal_start during calibration is ignored
        run_cal("T5", 9, 8, 1'b1);

        // RUN sampling
        model_on = 1'b0;
        cmp_man = 1'b1;
        wait_pulse(n);
        check("T4 first_pulse", n, RUN_PERIOD);
        check("T4 bit_high", sample_bit, 1);
        cmp_man = 1'b0;
        @(negedge clk);
        check("T4 pulse_width", sample_valid, 0);
        wait_pulse(n);
        check("T4 period", n, RUN_PERIOD - 1);
        check("T4 bit_low", sample_bit, 0);

        // Random comparator stream; sample_bit reflects cmp_in two edges before the pulse edge
        last_pulse = 0;
        pulses = 0;
        for (int m = 0; m < 64; m++) begin
            if (m > 0 && sample_valid) begin
                pulses++;
                check($sformatf("T4r spacing@%0d", m), m - last_pulse, RUN_PERIOD);
                check($sformatf("T4r bit@%0d", m), sample_bit, hist[m - 3]);
                last_pulse = m;
            end
            v = int'($urandom_range(1, 0));
            cmp_man = v[0];
            hist.push_back(v);
            @(negedge clk);
        end
        check("T4r pulses", pulses, 3);

        // Asynchronous reset mid-RUN
        #2 rst_n = 1'b0;
        #1 check_all_zero("T1 async");
        @(negedge clk);
        rst_n = 1'b1;
        activity = 0;
        repeat (20) begin
            @(negedge clk);
            if (sample_valid || cal_busy || ota_en || short_en || cal_done) activity++;
        end
        check("T1 idle_quiet", activity, 0);

        // Asynchronous reset mid-calibration
        model_on = 1'b1;
        thr = 9;
        cal_start = 1'b1;
        @(negedge clk);
        cal_start = 1'b0;
        repeat (6) @(negedge clk);
        check("RC busy_before", cal_busy, 1);
        check("RC trim_before", int'(trim_code), 12);
        #2 rst_n = 1'b0;
        #1 check_all_zero("RC async");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // ena dropped during the third SAR bit
        cal_start = 1'b1;
        @(negedge clk);
        cal_start = 1'b0;
        repeat (10) @(negedge clk);
        check("T6 trial3", int'(trim_code), 10);
        ena = 1'b0;
        @(negedge clk);
        check("T6 busy", cal_busy, 0);
        check("T6 short", short_en, 0);
        check("T6 ota", ota_en, 0);
        check("T6 done", cal_done, 0);
        check("T6 trim", int'(trim_code), 8);
        ena = 1'b1;
        activity = 0;
        repeat (20) begin
            @(negedge clk);
            if (sample_valid || cal_busy || ota_en || short_en) activity++;
        end
        check("T6 idle_quiet", activity, 0);
        check("T6 trim_hold", int'(trim_code), 8);

        // ena low has priority over cal_start in RUN
        run_cal("PR", 16, 15, 1'b0);
        ena = 1'b0;
        cal_start = 1'b1;
        @(negedge clk);
        ena = 1'b1;
        cal_start = 1'b0;
        check("PR busy", cal_busy, 0);
        check("PR ota", ota_en, 0);
        check("PR done", cal_done, 0);
        check("PR trim", int'(trim_code), 15);
        @(negedge clk);
        check("PR stays_idle", cal_busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
